stall_controller: RTL and testbench



---
 rtl/mips_pkg.sv | 15 +
 rtl/sat_down_counter.sv | 25 ++
 rtl/stall_controller.sv | 157 +++++++++++++++
 tb/tb_stall_controller.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline-control types and constants for the MIPS core.
package mips_pkg;

  typedef enum logic [2:0] {
    RUN,
    STALL,
    RESUME,
    DRAIN,
    HALTED
  } ctrl_state_t;

  localparam int unsigned STALL_CNT_W = 2;
  localparam logic [5:0]  HALT_OPCODE = 6'h11;

endpackage

// File: rtl/sat_down_counter.sv
// Loadable down-counter that floors at zero; load wins over decrement.
module sat_down_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/stall_controller.sv
// Pipeline stall / flush / halt-drain sequencer.
// Optional STALL_STATS_EN adds saturating stall-cycle and flush counters.
module stall_controller #(
  parameter int unsigned STALL_CNT_W  = mips_pkg::STALL_CNT_W,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter logic [5:0]  HALT_OPCODE  = mips_pkg::HALT_OPCODE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hazard,
  input  logic [STALL_CNT_W-1:0] count,
  input  logic [5:0]             id_opcode,
  input  logic                   branch_taken,
  output logic                   pc_we,
  output logic                   ifid_we,
  output logic                   ifid_flush,
  output logic                   idex_bubble,
  output logic                   stalled,
  output logic                   halted_o
`ifdef STALL_STATS_EN
  ,
  output logic [31:0]            stall_cycles,
  output logic [15:0]            flush_count
`endif
);

  import mips_pkg::*;

  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  ctrl_state_t state, state_nxt;

  logic [STALL_CNT_W-1:0] stall_cnt, stall_load_val;
  logic                   stall_load, stall_dec, stall_zero;
  logic [DRAIN_W-1:0]     drain_cnt, drain_load_val;
  logic                   drain_load, drain_dec, drain_zero;

  sat_down_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (stall_load),
    .load_val (stall_load_val),
    .dec      (stall_dec),
    .cnt      (stall_cnt),
    .zero     (stall_zero)
  );

  sat_down_counter #(.W(DRAIN_W)) u_drain_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (drain_load),
    .load_val (drain_load_val),
    .dec      (drain_dec),
    .cnt      (drain_cnt),
    .zero     (drain_zero)
  );

  always_comb begin
    state_nxt      = state;
    pc_we          = 1'b1;
    ifid_we        = 1'b1;
    ifid_flush     = 1'b0;
    idex_bubble    = 1'b0;
    stalled        = (state == STALL);
    halted_o       = 1'b0;
    stall_load     = 1'b0;
    stall_load_val = '0;
    stall_dec      = 1'b0;
    drain_load     = 1'b0;
    drain_load_val = '0;
    drain_dec      = 1'b0;

    if (state != HALTED && branch_taken) begin
      // Taken branch overrides everything outside HALTED; pending counts are dropped.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      stall_load  = 1'b1;
      drain_load  = 1'b1;
      state_nxt   = RUN;
    end else begin
      case (state)
        RUN: begin
          if (hazard) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            if (count > STALL_CNT_W'(1)) begin
              state_nxt      = STALL;
              stall_load     = 1'b1;
              stall_load_val = count - STALL_CNT_W'(1);
            end
          end else if (id_opcode == HALT_OPCODE) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            // This cycle counts as the first drain cycle, hence the minus one.
            if (DRAIN_CYCLES > 1) begin
              state_nxt      = DRAIN;
              drain_load     = 1'b1;
              drain_load_val = DRAIN_W'(DRAIN_CYCLES - 1);
            end else begin
              state_nxt = HALTED;
            end
          end
        end
        STALL: begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
          stall_dec   = 1'b1;
          if (stall_cnt == STALL_CNT_W'(1) || stall_zero)
            state_nxt = RESUME;
        end
        RESUME: state_nxt = RUN;
        DRAIN: begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
          drain_dec   = 1'b1;
          if (drain_cnt == DRAIN_W'(1) || drain_zero)
            state_nxt = HALTED;
        end
        HALTED: begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
          halted_o    = 1'b1;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= RUN;
    else
      state <= state_nxt;
  end

`ifdef STALL_STATS_EN
  logic haz_bubble;
  assign haz_bubble = idex_bubble && !ifid_flush && (state == RUN || state == STALL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (haz_bubble && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (ifid_flush && (flush_count != '1))
        flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stall_controller.sv
// Scoreboard bench for stall_controller; per-cycle expectations are queued at drive time.
module tb_stall_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hazard;
  logic [1:0] count;
  logic [5:0] id_opcode;
  logic       branch_taken;
  logic       pc_we, ifid_we, ifid_flush, idex_bubble, stalled, halted_o;
`ifdef STALL_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  stall_controller #(
    .STALL_CNT_W  (2),
    .DRAIN_CYCLES (4),
    .HALT_OPCODE  (6'h11)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hazard       (hazard),
    .count        (count),
    .id_opcode    (id_opcode),
    .branch_taken (branch_taken),
    .pc_we        (pc_we),
    .ifid_we      (ifid_we),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .stalled      (stalled),
    .halted_o     (halted_o)
`ifdef STALL_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  always #5 clk = ~clk;

  // Output vector order: {pc_we, ifid_we, ifid_flush, idex_bubble, stalled, halted_o}
  localparam logic [5:0] RUNO  = 6'b110000;
  localparam logic [5:0] BUB   = 6'b000100;
  localparam logic [5:0] STL   = 6'b000110;
  localparam logic [5:0] FLS   = 6'b111100;
  localparam logic [5:0] FLS_S = 6'b111110;
  localparam logic [5:0] HRUN  = 6'b000000;
  localparam logic [5:0] DRN   = 6'b000100;
  localparam logic [5:0] HLT   = 6'b000101;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [5:0] exp_q[$];
  string      tag_q[$];

  function automatic logic [5:0] outs();
    return {pc_we, ifid_we, ifid_flush, idex_bubble, stalled, halted_o};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic hz, input logic [1:0] cn, input logic [5:0] op, input logic br);
    @(posedge clk);
    #1;
    hazard       = hz;
    count        = cn;
    id_opcode    = op;
    branch_taken = br;
  endtask

  task automatic cyc(input logic hz, input logic [1:0] cn, input logic [5:0] op,
                     input logic br, input logic [5:0] ex, input string tg);
    drive(hz, cn, op, br);
    exp_q.push_back(ex);
    tag_q.push_back(tg);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [5:0] e;
      string      t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, {26'd0, outs()}, {26'd0, e});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; hazard = 1'b0; count = 2'd0; id_opcode = 6'h00; branch_taken = 1'b0;
    #1;
    check_eq("reset_outs", {26'd0, outs()}, {26'd0, RUNO});
    @(posedge clk); #1; rst_n = 1'b1;

    cyc(0, 0, 6'h00, 0, RUNO, "idle0");
    cyc(0, 0, 6'h00, 0, RUNO, "idle1");

    // count=2: bubble, one STALL cycle, RESUME ignores hazard, then normal
    cyc(1, 2, 6'h00, 0, BUB,  "c2_run");
    cyc(1, 2, 6'h00, 0, STL,  "c2_stall");
    cyc(1, 2, 6'h00, 0, RUNO, "c2_resume");
    cyc(0, 0, 6'h00, 0, RUNO, "c2_after");

    // count=0 and count=1 give a single bubble and no STALL
    cyc(1, 0, 6'h00, 0, BUB,  "c0_run");
    cyc(0, 0, 6'h00, 0, RUNO, "c0_after");
    cyc(1, 1, 6'h00, 0, BUB,  "c1_run");
    cyc(0, 0, 6'h00, 0, RUNO, "c1_after");

    // count=3 with branch on the second stall cycle
    cyc(1, 3, 6'h00, 0, BUB,   "c3_run");
    cyc(1, 3, 6'h00, 0, STL,   "c3_stall1");
    cyc(1, 3, 6'h00, 1, FLS_S, "c3_br_stall2");
    cyc(0, 0, 6'h00, 0, RUNO,  "c3_after_br");
    cyc(0, 0, 6'h00, 0, RUNO,  "c3_after_br2");

    // branch wins over hazard in RUN, and branch during RESUME
    cyc(1, 2, 6'h00, 1, FLS,  "br_haz_run");
    cyc(0, 0, 6'h00, 0, RUNO, "br_haz_after");
    cyc(1, 2, 6'h00, 0, BUB,  "brres_run");
    cyc(1, 2, 6'h00, 0, STL,  "brres_stall");
    cyc(0, 0, 6'h00, 1, FLS,  "brres_resume");
    cyc(0, 0, 6'h00, 0, RUNO, "brres_after");

    // HALT flushed by a branch during drain
    cyc(0, 0, 6'h11, 0, HRUN, "hflush_run");
    cyc(0, 0, 6'h00, 1, FLS,  "hflush_br");
    cyc(0, 0, 6'h00, 0, RUNO, "hflush_after");

    // HALT behind a hazard: stall first, then full drain into sticky HALTED
    cyc(1, 0, 6'h11, 0, BUB,  "halt_haz");
    cyc(0, 0, 6'h11, 0, HRUN, "halt_c0");
    cyc(0, 0, 6'h00, 0, DRN,  "halt_c1");
    cyc(0, 0, 6'h00, 0, DRN,  "halt_c2");
    cyc(0, 0, 6'h00, 0, DRN,  "halt_c3");
    cyc(0, 0, 6'h00, 0, HLT,  "halt_c4");
    cyc(1, 3, 6'h00, 1, HLT,  "halt_sticky_br");
    cyc(1, 2, 6'h11, 0, HLT,  "halt_sticky_haz");
    cyc(0, 0, 6'h00, 0, HLT,  "halt_sticky");

    // leave HALTED via asynchronous reset
    drive(0, 0, 6'h00, 0);
    #2 rst_n = 1'b0;
    #1 check_eq("rst_from_halt", {26'd0, outs()}, {26'd0, RUNO});
    @(posedge clk); #1; rst_n = 1'b1;

    // async reset while in STALL with stall_cnt=2
    cyc(1, 3, 6'h00, 0, BUB, "rst_stall_run");
    drive(0, 0, 6'h00, 0);
    #2 rst_n = 1'b0;
    #1 check_eq("rst_mid_stall", {26'd0, outs()}, {26'd0, RUNO});
    @(posedge clk); #1;
    check_eq("rst_held", {26'd0, outs()}, {26'd0, RUNO});
    rst_n = 1'b1;
    cyc(0, 0, 6'h00, 0, RUNO, "post_rst0");
    cyc(0, 0, 6'h00, 0, RUNO, "post_rst1");
    cyc(1, 0, 6'h00, 0, BUB,  "post_rst_haz");
    cyc(0, 0, 6'h00, 0, RUNO, "post_rst_after");

`ifdef STALL_STATS_EN
    drive(0, 0, 6'h00, 0);
    #2 rst_n = 1'b0;
    #1 check_eq("stats_rst_stall", stall_cycles, 32'd0);
    check_eq("stats_rst_flush", {16'd0, flush_count}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(1, 2, 6'h00, 0, BUB,  "st_run");
      cyc(1, 2, 6'h00, 0, STL,  "st_stall");
      cyc(0, 0, 6'h00, 0, RUNO, "st_resume");
    end
    cyc(0, 0, 6'h00, 1, FLS,  "st_flush");
    cyc(0, 0, 6'h00, 0, RUNO, "st_after");
    @(negedge clk); #1;
    check_eq("stats_stall_cycles", stall_cycles, 32'd4);
    check_eq("stats_flush_count", {16'd0, flush_count}, 32'd1);
`endif

    @(negedge clk); #1;
    if (exp_q.size() != 0)
      check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
